// File: rtl/regfile_pkg.sv
// Purpose : shared constants and types for the register-file write arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default DATA_W/ADDR_W, per-register outstanding-write counter limit,
// and the requester-id enum used by the round-robin pointer.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  // Largest value of the 2-bit outstanding-write counter; reservations stall here.
  localparam logic [1:0] CNT_MAX = 2'd3;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Purpose : bundles the writeback requesters, reservation port, register-file write port and status.
// Latency : n/a (signal bundle only).
// Backpressure: valid/ready on alu, mem and reserve; the slave drives the readies.
//
// Ports (slave view): alu_*/mem_* writeback requests in, reserve_* reservation in,
// rf_* write port out, busy_mask out, err_unreserved out (only when RF_ERR_EN is defined).
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;

  logic              reserve_valid;
  logic              reserve_ready;
  logic [ADDR_W-1:0] reserve_reg;

  logic              rf_regWrite;
  logic [ADDR_W-1:0] rf_writeRegister;
  logic [DATA_W-1:0] rf_writeData;

  logic [NUM_REGS-1:0] busy_mask;
`ifdef RF_ERR_EN
  logic              err_unreserved;
`endif

  modport master (
    output alu_valid, alu_reg, alu_data,
    input  alu_ready,
    output mem_valid, mem_reg, mem_data,
    input  mem_ready,
    output reserve_valid, reserve_reg,
    input  reserve_ready,
    input  rf_regWrite, rf_writeRegister, rf_writeData,
    input  busy_mask
`ifdef RF_ERR_EN
    , input err_unreserved
`endif
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    output alu_ready,
    input  mem_valid, mem_reg, mem_data,
    output mem_ready,
    input  reserve_valid, reserve_reg,
    output reserve_ready,
    output rf_regWrite, rf_writeRegister, rf_writeData,
    output busy_mask
`ifdef RF_ERR_EN
    , output err_unreserved
`endif
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Purpose : two-way round-robin arbiter, one-hot grant.
// Latency : grant is combinational from req and the pointer; pointer updates on the granting edge.
// Backpressure: every grant is a transfer (requesters hold valid until granted).
//
// Ports: clock, reset_n (async active-low), req[1:0] (bit0 = ALU, bit1 = MEM), grant[1:0] one-hot.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_e last_q, last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contested: whoever did not win last time goes now.
      2'b11:   grant = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      last_d = REQ_ALU;
    end else if (grant[1]) begin
      last_d = REQ_MEM;
    end
  end

  // Reset to "MEM granted last" so the ALU wins the first contested cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= REQ_MEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose : arbitrates ALU and load writebacks onto one register-file write port and tracks reservations.
// Latency : 1 cycle from accepted transfer to rf_regWrite; busy_mask registered.
// Backpressure: one writeback ready per cycle (round-robin); reserve_ready low when the target counter is saturated.
//
// Ports: clock, reset_n (async active-low), bus (regfile_write_arbiter_if.slave).
// Optional: define RF_ERR_EN to add the sticky err_unreserved flag (writes to an unreserved register).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                    clock,
  input logic                    reset_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [1:0]          req;
  logic [1:0]          grant;
  logic                xfer;
  logic                rsv_fire;
  logic [ADDR_W-1:0]   xfer_reg;
  logic [DATA_W-1:0]   xfer_data;

  logic [NUM_REGS-1:0][1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [NUM_REGS-1:0]      rsv_hit, wr_hit;

  logic                we_q;
  logic [ADDR_W-1:0]   wreg_q;
  logic [DATA_W-1:0]   wdata_q;

  assign req = {bus.mem_valid, bus.alu_valid};

  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .grant   (grant)
  );

  // Readies are forced low while in reset; grant already implies valid.
  assign bus.alu_ready     = reset_n & grant[0];
  assign bus.mem_ready     = reset_n & grant[1];
  assign bus.reserve_ready = reset_n & (cnt_q[bus.reserve_reg] != CNT_MAX);

  assign xfer      = reset_n & (grant[0] | grant[1]);
  assign rsv_fire  = bus.reserve_valid & reset_n & (cnt_q[bus.reserve_reg] != CNT_MAX);
  assign xfer_reg  = grant[1] ? bus.mem_reg  : bus.alu_reg;
  assign xfer_data = grant[1] ? bus.mem_data : bus.alu_data;

  // A reservation and a write to the same register on one edge cancel out;
  // a write to an idle register leaves its counter at zero.
  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = '0;
    rsv_hit = '0;
    wr_hit  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rsv_hit[i] = rsv_fire && (bus.reserve_reg == ADDR_W'(i));
      wr_hit[i]  = xfer && (xfer_reg == ADDR_W'(i));
      if (rsv_hit[i] && !wr_hit[i]) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (wr_hit[i] && !rsv_hit[i] && (cnt_q[i] != 2'd0)) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
      busy_d[i] = (cnt_d[i] != 2'd0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      busy_q  <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      we_q   <= xfer;
      if (xfer) begin
        wreg_q  <= xfer_reg;
        wdata_q <= xfer_data;
      end
    end
  end

  assign bus.rf_regWrite      = we_q;
  assign bus.rf_writeRegister = wreg_q;
  assign bus.rf_writeData     = wdata_q;
  assign bus.busy_mask        = busy_q;

`ifdef RF_ERR_EN
  logic err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (xfer && (cnt_q[xfer_reg] == 2'd0)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_unreserved = err_q;
`endif

endmodule
